// File: rtl/full_addsub_serial_n_bits.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock, LSB digit first,
// and publishes S/BOUT/OVF only when the whole word has been computed.
module full_addsub_serial_n_bits #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             bin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             bout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [WIDTH-1:0]     res_r;
    logic [WIDTH-1:0]     res_s;
    logic [WIDTH+DIGIT-1:0] wide_s;
    logic                 mode_r;
    logic                 carry_r;
    logic                 a_msb_r;
    logic                 b_msb_r;
    logic [CW-1:0]        cnt_r;
    logic [DIGIT:0]       dig_s;
    logic                 last_s;
    logic                 ovf_s;
    logic                 busy_r;
    logic                 done_r;

    // Ripple add/subtract of one digit; result is {carry/borrow out, digit}.
    function automatic logic [DIGIT:0] digit_op(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             cin,
        input logic             add
    );
        logic             c;
        logic [DIGIT-1:0] d;
        c = cin;
        d = {DIGIT{1'b0}};
        for (int i = 0; i < DIGIT; i++) begin
            d[i] = x[i] ^ y[i] ^ c;
            if (add) begin
                c = (x[i] & y[i]) | ((x[i] ^ y[i]) & c);
            end else begin
                c = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & c);
            end
        end
        return {c, d};
    endfunction

    // Current digit result and the partial word it would produce if shifted in.
    always_comb begin
        dig_s  = digit_op(a_r[DIGIT-1:0], b_r[DIGIT-1:0], carry_r, mode_r);
        wide_s = {dig_s[DIGIT-1:0], res_r} >> DIGIT;
        res_s  = wide_s[WIDTH-1:0];
        last_s = (cnt_r == CW'(N - 1));
        ovf_s  = mode_r ? ((a_msb_r == b_msb_r) && (res_s[WIDTH-1] != a_msb_r))
                        : ((a_msb_r != b_msb_r) && (res_s[WIDTH-1] != a_msb_r));
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = FIN;
                end else begin
                    state_s = RUN;
                end
            end
            FIN:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, operand shift registers and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            mode_r  <= 1'b0;
            carry_r <= 1'b0;
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            s       <= {WIDTH{1'b0}};
            bout    <= 1'b0;
            ovf     <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == FIN);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        mode_r  <= mode;
                        carry_r <= bin;
                        a_msb_r <= a[WIDTH-1];
                        b_msb_r <= b[WIDTH-1];
                        res_r   <= {WIDTH{1'b0}};
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    a_r     <= a_r >> DIGIT;
                    b_r     <= b_r >> DIGIT;
                    carry_r <= dig_s[DIGIT];
                    res_r   <= res_s;
                    cnt_r   <= cnt_r + CW'(1);
                    if (last_s) begin
                        s    <= res_s;
                        bout <= dig_s[DIGIT];
                        ovf  <= ovf_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_full_addsub_serial_n_bits.sv
// Directed bench: DIGIT=1, 4 and 8 builds run the same vectors side by side.
module tb_full_addsub_serial_n_bits;

    logic       clk;
    logic       rst;
    logic       start;
    logic       mode;
    logic       bin;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s_w    [3];
    logic       bout_w [3];
    logic       ovf_w  [3];
    logic       busy_w [3];
    logic       done_w [3];
    int         nd     [3] = '{8, 2, 1};
    int         n_chk;
    int         n_bad;
    logic [7:0] prev_s;

    full_addsub_serial_n_bits #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .bin(bin), .a(a), .b(b),
        .s(s_w[0]), .bout(bout_w[0]), .ovf(ovf_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    full_addsub_serial_n_bits #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .bin(bin), .a(a), .b(b),
        .s(s_w[1]), .bout(bout_w[1]), .ovf(ovf_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    full_addsub_serial_n_bits #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .bin(bin), .a(a), .b(b),
        .s(s_w[2]), .bout(bout_w[2]), .ovf(ovf_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One operation on all three builds; operands scrambled after the accepting edge.
    task automatic run_op(input string tag, input logic m, input logic bi,
                          input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] es, input logic eb, input logic eo,
                          input bit glitch);
        @(negedge clk);
        mode = m; bin = bi; a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~av; b = ~bv; mode = ~m; bin = ~bi;
        for (int j = 0; j < 10; j++) begin
            for (int k = 0; k < 3; k++)
                check_val($sformatf("%s_done_d%0d_c%0d", tag, k, j), {31'd0, done_w[k]},
                          (j == nd[k]) ? 32'd1 : 32'd0);
            if (j < 8) begin
                check_val($sformatf("%s_busy_c%0d", tag, j), {31'd0, busy_w[0]}, 32'd1);
                check_val($sformatf("%s_hold_c%0d", tag, j), {24'd0, s_w[0]}, {24'd0, prev_s});
            end
            start = (glitch && j == 1) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("%s_s_d%0d", tag, k), {24'd0, s_w[k]}, {24'd0, es});
            check_val($sformatf("%s_bout_d%0d", tag, k), {31'd0, bout_w[k]}, {31'd0, eb});
            check_val($sformatf("%s_ovf_d%0d", tag, k), {31'd0, ovf_w[k]}, {31'd0, eo});
        end
        prev_s = es;
    endtask

    initial begin
        n_chk = 0; n_bad = 0; prev_s = 8'h00;
        rst = 1'b1; start = 1'b1; mode = 1'b0; bin = 1'b0; a = 8'h5A; b = 8'h33;
        repeat (2) @(negedge clk);
        rst = 1'b0; start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("rst_s_d%0d", k), {24'd0, s_w[k]}, 32'd0);
            check_val($sformatf("rst_bout_d%0d", k), {31'd0, bout_w[k]}, 32'd0);
            check_val($sformatf("rst_ovf_d%0d", k), {31'd0, ovf_w[k]}, 32'd0);
            check_val($sformatf("rst_busy_d%0d", k), {31'd0, busy_w[k]}, 32'd0);
            check_val($sformatf("rst_done_d%0d", k), {31'd0, done_w[k]}, 32'd0);
        end
        @(negedge clk);
        check_val("rst_start_ignored", {31'd0, busy_w[0]}, 32'd0);

        run_op("sub_ff_00", 1'b0, 1'b0, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        run_op("sub_0f_02", 1'b0, 1'b0, 8'h0F, 8'h02, 8'h0D, 1'b0, 1'b0, 1'b0);
        run_op("sub_3c_0a", 1'b0, 1'b0, 8'h3C, 8'h0A, 8'h32, 1'b0, 1'b0, 1'b0);
        run_op("sub_92_06", 1'b0, 1'b0, 8'h92, 8'h06, 8'h8C, 1'b0, 1'b0, 1'b0);
        run_op("sub_00_01", 1'b0, 1'b0, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
        run_op("sub_80_01", 1'b0, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
        run_op("sub_05_05_b", 1'b0, 1'b1, 8'h05, 8'h05, 8'hFF, 1'b1, 1'b0, 1'b0);
        run_op("add_7f_01", 1'b1, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op("add_ff_01", 1'b1, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op("add_12_34_c", 1'b1, 1'b1, 8'h12, 8'h34, 8'h47, 1'b0, 1'b0, 1'b0);

        // Abort an operation with reset a few cycles into RUN.
        @(negedge clk);
        mode = 1'b0; bin = 1'b0; a = 8'hFF; b = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++)
            check_val($sformatf("abort_s_d%0d", k), {24'd0, s_w[k]}, 32'd0);
        for (int j = 0; j < 10; j++) begin
            check_val($sformatf("abort_done_c%0d", j), {31'd0, done_w[0]}, 32'd0);
            check_val($sformatf("abort_busy_c%0d", j), {31'd0, busy_w[0]}, 32'd0);
            @(negedge clk);
        end
        prev_s = 8'h00;
        run_op("after_abort", 1'b0, 1'b0, 8'h0F, 8'h02, 8'h0D, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
